// File: rtl/specialist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : specialist_pkg
// Purpose  : Shared types and constants for the Specialist RKS loader.
//            Holds the loader state encoding, the err code values reported
//            on rks_loader.err and the fixed RKS header length.
// Revision : 1.0  initial release
// ============================================================================
package specialist_pkg;

  // Loader states; explicit 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } rks_state_t;

  // err output codes
  localparam logic [1:0] ERR_NONE  = 2'd0;  // no error
  localparam logic [1:0] ERR_RANGE = 2'd1;  // end < start, or ROM window hit
  localparam logic [1:0] ERR_TRUNC = 2'd2;  // load dropped before the file ended
  localparam logic [1:0] ERR_CSUM  = 2'd3;  // trailing checksum mismatch

  // start lo, start hi, end lo, end hi
  localparam logic [2:0] RKS_HDR_LEN = 3'd4;

endpackage : specialist_pkg
`default_nettype wire

// File: rtl/rks_csum.sv
`default_nettype none
// ============================================================================
// Module   : rks_csum
// Purpose  : 16-bit RKS checksum accumulator (Specialist/RK convention).
//            Every byte but the last adds b*0x0101; the last byte adds only
//            into the low byte with no carry into the high byte.
// Ports    : clk_sys  in   system clock
//            reset    in   asynchronous, active-high
//            clear    in   zero the sum (takes priority over add)
//            add      in   accumulate din this cycle
//            last     in   din is the final payload byte
//            din      in   payload byte
//            sum      out  running checksum
// Revision : 1.0  initial release
// ============================================================================
module rks_csum (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clear,
  input  logic        add,
  input  logic        last,
  input  logic [7:0]  din,
  output logic [15:0] sum
);

  logic [15:0] r_sum;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
    end else if (clear) begin
      r_sum <= '0;
    end else if (add) begin
      if (last) begin
        // Low byte only: the carry out of bit 7 is deliberately dropped.
        r_sum[7:0] <= r_sum[7:0] + din;
      end else begin
        r_sum <= r_sum + {din, din};
      end
    end
  end

  assign sum = r_sum;

endmodule : rks_csum
`default_nettype wire

// File: rtl/rks_loader.sv
`default_nettype none
// ============================================================================
// Module   : rks_loader
// Purpose  : Parses an .RKS download stream (start, end, payload, checksum)
//            into CPU-address memory writes, verifies the trailing checksum
//            and reports the entry address for the post-load jump.
// Ports    : clk_sys    in   system clock
//            reset      in   asynchronous, active-high
//            load       in   RKS download active (level)
//            wr         in   ioctl byte strobe, foreign-domain level
//            din        in   ioctl byte, stable while wr is high
//            mem_we     out  one-cycle memory write pulse
//            mem_addr   out  CPU address of the current payload byte
//            mem_data   out  payload byte
//            busy       out  file being received
//            done       out  file accepted
//            err        out  error code (see specialist_pkg)
//            start_addr out  parsed start address
//            go         out  one-cycle pulse on successful completion
// Revision : 1.0  initial release
// ============================================================================
module rks_loader #(
  parameter logic [15:0] ROM_BASE    = 16'hC000,
  parameter bit          ROM_PROTECT = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        load,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [15:0] start_addr,
  output logic        go
);
  import specialist_pkg::*;

  // wr synchroniser plus one history flop for edge detection
  logic r_wr_s1, r_wr_s2, r_wr_s3;
  logic w_byte;

  // r_load_d resets high so a load already asserted when reset releases
  // is not mistaken for a fresh rise.
  logic r_load_d;
  logic w_load_rise, w_load_fall;

  rks_state_t  r_state, w_state_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [15:0] r_start, w_start_nxt;
  logic [7:0]  r_end_lo, w_end_lo_nxt;
  logic [15:0] r_addr, w_addr_nxt;
  logic [16:0] r_remaining, w_remaining_nxt;
  logic [7:0]  r_csum_lo, w_csum_lo_nxt;
  logic [1:0]  r_err, w_err_nxt;

  logic        w_csum_clr, w_csum_add, w_csum_last, w_data_stb;
  logic [15:0] w_sum, w_end, w_csum_rx;

  logic        r_we_pend, r_mem_we, r_go;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_data;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_s1  <= 1'b0;
      r_wr_s2  <= 1'b0;
      r_wr_s3  <= 1'b0;
      r_load_d <= 1'b1;
    end else begin
      r_wr_s1  <= wr;
      r_wr_s2  <= r_wr_s1;
      r_wr_s3  <= r_wr_s2;
      r_load_d <= load;
    end
  end

  assign w_byte      = r_wr_s2 & ~r_wr_s3;
  assign w_load_rise = load & ~r_load_d;
  assign w_load_fall = ~load & r_load_d;
  assign w_end       = {din, r_end_lo};
  assign w_csum_rx   = {din, r_csum_lo};

  rks_csum u_csum (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (w_csum_clr),
    .add     (w_csum_add),
    .last    (w_csum_last),
    .din     (din),
    .sum     (w_sum)
  );

  // State register and all FSM-owned datapath registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_start     <= '0;
      r_end_lo    <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_csum_lo   <= '0;
      r_err       <= ERR_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_start     <= w_start_nxt;
      r_end_lo    <= w_end_lo_nxt;
      r_addr      <= w_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_csum_lo   <= w_csum_lo_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_start_nxt     = r_start;
    w_end_lo_nxt    = r_end_lo;
    w_addr_nxt      = r_addr;
    w_remaining_nxt = r_remaining;
    w_csum_lo_nxt   = r_csum_lo;
    w_err_nxt       = r_err;
    w_csum_clr      = 1'b0;
    w_csum_add      = 1'b0;
    w_csum_last     = 1'b0;
    w_data_stb      = 1'b0;

    if (w_load_rise) begin
      w_state_nxt = HDR;
      w_idx_nxt   = '0;
      w_err_nxt   = ERR_NONE;
      w_csum_clr  = 1'b1;
    end else begin
      case (r_state)
        HDR: begin
          if (w_byte) begin
            w_idx_nxt = r_idx + 3'd1;
            if (r_idx == RKS_HDR_LEN - 3'd1) begin
              if ((w_end < r_start) || (ROM_PROTECT && (w_end >= ROM_BASE))) begin
                w_state_nxt = ERR;
                w_err_nxt   = ERR_RANGE;
              end else begin
                w_state_nxt     = DATA;
                w_addr_nxt      = r_start;
                w_remaining_nxt = {1'b0, w_end} - {1'b0, r_start} + 17'd1;
              end
            end else begin
              case (r_idx[1:0])
                2'd0:    w_start_nxt[7:0]  = din;
                2'd1:    w_start_nxt[15:8] = din;
                default: w_end_lo_nxt      = din;
              endcase
            end
          end
        end
        DATA: begin
          if (w_byte) begin
            w_data_stb      = 1'b1;
            w_csum_add      = 1'b1;
            w_csum_last     = (r_remaining == 17'd1);
            w_addr_nxt      = r_addr + 16'd1;
            w_remaining_nxt = r_remaining - 17'd1;
            if (r_remaining == 17'd1) begin
              w_state_nxt = CSUM;
              w_idx_nxt   = '0;
            end
          end
        end
        CSUM: begin
          if (w_byte) begin
            if (r_idx == 3'd0) begin
              w_csum_lo_nxt = din;
              w_idx_nxt     = 3'd1;
            end else if (w_csum_rx == w_sum) begin
              w_state_nxt = DONE;
            end else begin
              w_state_nxt = ERR;
              w_err_nxt   = ERR_CSUM;
            end
          end
        end
        default: ;
      endcase

      // The byte of this cycle is already folded in above; a fall only
      // aborts if that byte did not itself finish the file.
      if (w_load_fall &&
          ((w_state_nxt == HDR) || (w_state_nxt == DATA) || (w_state_nxt == CSUM))) begin
        w_state_nxt = ERR;
        w_err_nxt   = ERR_TRUNC;
      end
    end
  end

  // Write pipeline: address/data latched on the byte cycle, pulse one later.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_we_pend  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_go       <= 1'b0;
    end else begin
      r_we_pend <= w_data_stb;
      r_mem_we  <= r_we_pend;
      if (w_data_stb) begin
        r_mem_addr <= r_addr;
        r_mem_data <= din;
      end
      r_go <= (w_state_nxt == DONE) && (r_state != DONE);
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign busy       = (r_state == HDR) || (r_state == DATA) || (r_state == CSUM);
  assign done       = (r_state == DONE);
  assign err        = r_err;
  assign start_addr = r_start;
  assign go         = r_go;

endmodule : rks_loader
`default_nettype wire

// File: doc/rks_loader.md
Name: rks_loader

Overview:
- Sits between the ARM I/O download stream (ioctl index 1, ".RKS" file) and the SDRAM write port.
- Parses the RKS container and turns the payload into CPU-address RAM writes.
- Verifies the trailing checksum and reports the program entry address for the post-load CPU jump.
- Replaces the raw ioctl_addr pass-through for RKS loads.

Parameters:
ROM_BASE, 16'hC000, first address of the ROM window; payload bytes at or above it are rejected when ROM_PROTECT=1.
ROM_PROTECT, 1, 1 = reject files whose end address is >= ROM_BASE; 0 = no check.

Ports:
clk_sys  in  1  system clock, 48 MHz
reset  in  1  asynchronous, active-high
load  in  1  RKS download active (ioctl_download && index==1); level
wr  in  1  ioctl byte strobe, clk_io domain level; edge-detected internally
din  in  8  ioctl byte, stable while wr high
mem_we  out  1  one-clk_sys write pulse to SDRAM
mem_addr  out  16  CPU address of the current payload byte
mem_data  out  8  payload byte
busy  out  1  high from load rise until DONE or ERR
done  out  1  high in DONE until the next load rise or reset
err  out  2  0 none, 1 end<start or ROM hit, 2 truncated, 3 checksum mismatch
start_addr  out  16  parsed start address, valid when done=1
go  out  1  one-cycle pulse on DONE entry with err==0

Behaviour:
- Reset values: all outputs 0; state IDLE.
- wr sampled through a 2-flop synchroniser. A byte is taken on the synchronised rising edge, at most one per edge. Byte index counter is 3 bits for the header and 17 bits for the payload.
- Byte layout: start lo, start hi, end lo, end hi, payload (end-start+1 bytes), csum lo, csum hi. All fields little-endian.
- FSM:
  - IDLE: on load rise → HDR; clear done, err, checksum; set busy.
  - HDR: collect 4 bytes. On the 4th byte:
    - if end<start, or ROM_PROTECT && end>=ROM_BASE → ERR with err=1;
    - else → DATA with addr=start, remaining=end-start+1 (17-bit; start=0000, end=FFFF gives 65536).
  - DATA: per byte
    - mem_we=1 exactly one clk_sys cycle, 2 cycles after the synchronised edge; mem_addr and mem_data held stable until the next byte;
    - addr+=1; remaining-=1;
    - if remaining was 1 → CSUM.
  - CSUM: 2 bytes. On the 2nd byte, DONE if equal to the computed sum, else ERR with err=3.
  - DONE / ERR: hold; ignore further bytes; busy=0. Return to HDR only on a new load rise.
- Checksum (Specialist/RK convention), 16-bit cs starting at 0:
  - every payload byte except the last: cs = cs + b*0x0101 mod 2^16;
  - last byte: cs[7:0] = cs[7:0] + b, with no carry into the high byte.
- Load fall while in HDR, DATA or CSUM → ERR with err=2; no further mem_we.
- Load fall while in DONE or ERR: no effect.
- Reset mid-load → IDLE immediately, all outputs 0. A load still high after reset is not a new rise; the loader waits for the next rise.
- Byte edge and load fall in the same cycle: the byte is processed first, then the fall is evaluated.
- go is asserted only on the DONE entry cycle; the top level uses it to release CPU reset and jump to start_addr.

Decomposition:
- Package specialist_pkg holds the state enum (IDLE, HDR, DATA, CSUM, DONE, ERR), the err code constants and the RKS_HDR_LEN=4 constant.
- One sub-module, rks_csum: accumulator with clear, add and last inputs producing the 16-bit sum.
- Edge synchroniser and FSM stay inline.

Test Plan:
- Nominal load of bytes 00 00 02 00 01 02 03 06 03 → 3 mem_we pulses at addr 0000/0001/0002 with data 01/02/03; done=1; err=0; start_addr=0000; one go pulse.
- Same file with last byte 04 → 3 writes still occur; ERR entered; err=3; go never pulses.
- Header 00 10 00 0F (end<start) → no mem_we; err=1. With ROM_PROTECT=1, header 00 BF 00 C0 → err=1.
- Load drops after 2 payload bytes of a 5-byte file → exactly 2 mem_we; err=2; busy=0.
- Reset asserted during DATA with load still high → outputs 0. The next load rise with a valid file completes normally.
- Extra bytes after the checksum → no further mem_we; done stays 1. Two back-to-back valid files → done clears at the second rise.
